matmul_feed_ctrl: RTL and testbench

- Sequencer for the 4x4 systolic multiply array.
- On a start command it issues skewed per-lane reads to the Matrix A and Matrix B operand register banks, and drives the left and up edge inputs of the array with zero fill.
- Clears the PE accumulators before feeding and waits for the array to drain.
- Signals completion so the APB/scratchpad side can collect res_o_*.

---
 rtl/matmul_feed_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_matmul_feed_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_feed_ctrl.sv
// Operand feed sequencer for the 4x4 systolic multiply array: skewed bank reads, zero-filled edge data.
// Optional macro MATMUL_CTRL_CYCLE_CNT_EN adds cycle_cnt_o, a 16-bit busy-cycle counter.
module matmul_feed_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_DIM    = 4,
    parameter int DIM_W      = 3
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_i,
    input  logic [DIM_W-1:0]                dim_n_i,
    input  logic [DIM_W-1:0]                dim_k_i,
    input  logic [DIM_W-1:0]                dim_m_i,
    output logic [MAX_DIM-1:0]              a_rd_en_o,
    output logic [MAX_DIM*ADDR_WIDTH-1:0]   a_rd_addr_o,
    input  logic [MAX_DIM*DATA_WIDTH-1:0]   a_rd_data_i,
    output logic [MAX_DIM-1:0]              b_rd_en_o,
    output logic [MAX_DIM*ADDR_WIDTH-1:0]   b_rd_addr_o,
    input  logic [MAX_DIM*DATA_WIDTH-1:0]   b_rd_data_i,
    output logic [MAX_DIM*DATA_WIDTH-1:0]   left_o,
    output logic [MAX_DIM*DATA_WIDTH-1:0]   up_o,
    output logic                            clear_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            err_o
`ifdef MATMUL_CTRL_CYCLE_CNT_EN
    ,
    output logic [15:0]                     cycle_cnt_o
`endif
);

    localparam int CNT_W = $clog2(2 * MAX_DIM + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [DIM_W-1:0]              n_q, n_d, k_q, k_d, m_q, m_d;
    logic [MAX_DIM-1:0]            a_en_q, a_en_d, b_en_q, b_en_d;
    logic [MAX_DIM-1:0]            a_dly_q, a_dly_d, b_dly_q, b_dly_d;
    logic [MAX_DIM*ADDR_WIDTH-1:0] a_addr_q, a_addr_d, b_addr_q, b_addr_d;
    logic                          clear_q, clear_d, busy_q, busy_d;
    logic                          done_q, done_d, err_q, err_d;
    logic [CNT_W-1:0]              t_feed, t_drain;
    logic                          dims_ok;

    always_comb begin : next_state
        t_feed  = CNT_W'(k_q) + ((n_q > m_q) ? CNT_W'(n_q) : CNT_W'(m_q)) - CNT_W'(1);
        t_drain = CNT_W'(n_q) + CNT_W'(m_q);
        dims_ok = (dim_n_i != '0) && (dim_n_i <= DIM_W'(MAX_DIM)) &&
                  (dim_k_i != '0) && (dim_k_i <= DIM_W'(MAX_DIM)) &&
                  (dim_m_i != '0) && (dim_m_i <= DIM_W'(MAX_DIM));
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        k_d     = k_q;
        m_d     = m_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (dims_ok) begin
                        n_d     = dim_n_i;
                        k_d     = dim_k_i;
                        m_d     = dim_m_i;
                        state_d = CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                state_d = FEED;
                cnt_d   = '0;
            end
            FEED: begin
                if (cnt_q == t_feed - CNT_W'(1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == t_drain - CNT_W'(1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every control output leaves a flop.
    always_comb begin : next_outputs
        int tt;
        tt       = 0;
        a_en_d   = '0;
        b_en_d   = '0;
        a_addr_d = '0;
        b_addr_d = '0;
        for (int i = 0; i < MAX_DIM; i++) begin
            tt = int'(cnt_d) - i;
            if (state_d == FEED && DIM_W'(i) < n_d && tt >= 0 && tt < int'(k_d)) begin
                a_en_d[i] = 1'b1;
                a_addr_d[i*ADDR_WIDTH +: ADDR_WIDTH] =
                    ADDR_WIDTH'(i) * ADDR_WIDTH'(MAX_DIM) + ADDR_WIDTH'(tt);
            end
            if (state_d == FEED && DIM_W'(i) < m_d && tt >= 0 && tt < int'(k_d)) begin
                b_en_d[i] = 1'b1;
                b_addr_d[i*ADDR_WIDTH +: ADDR_WIDTH] =
                    ADDR_WIDTH'(tt) * ADDR_WIDTH'(MAX_DIM) + ADDR_WIDTH'(i);
            end
        end
        a_dly_d = a_en_q;
        b_dly_d = b_en_q;
        clear_d = (state_d == CLEAR);
        busy_d  = (state_d == CLEAR) || (state_d == FEED) || (state_d == DRAIN);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            n_q      <= '0;
            k_q      <= '0;
            m_q      <= '0;
            a_en_q   <= '0;
            b_en_q   <= '0;
            a_dly_q  <= '0;
            b_dly_q  <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            clear_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            k_q      <= k_d;
            m_q      <= m_d;
            a_en_q   <= a_en_d;
            b_en_q   <= b_en_d;
            a_dly_q  <= a_dly_d;
            b_dly_q  <= b_dly_d;
            a_addr_q <= a_addr_d;
            b_addr_q <= b_addr_d;
            clear_q  <= clear_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Bank data returns one cycle after the enable; the delayed enable zero-fills everything else.
    always_comb begin : edge_data
        left_o = '0;
        up_o   = '0;
        for (int i = 0; i < MAX_DIM; i++) begin
            if (a_dly_q[i]) left_o[i*DATA_WIDTH +: DATA_WIDTH] = a_rd_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            if (b_dly_q[i]) up_o[i*DATA_WIDTH +: DATA_WIDTH]   = b_rd_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign a_rd_en_o   = a_en_q;
    assign b_rd_en_o   = b_en_q;
    assign a_rd_addr_o = a_addr_q;
    assign b_rd_addr_o = b_addr_q;
    assign clear_o     = clear_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

`ifdef MATMUL_CTRL_CYCLE_CNT_EN
    logic [15:0] cycle_cnt_q, cycle_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (state_d == CLEAR) cycle_cnt_d = '0;
        else if (busy_q)      cycle_cnt_d = cycle_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cycle_cnt_q <= '0;
        else       cycle_cnt_q <= cycle_cnt_d;
    end

    assign cycle_cnt_o = cycle_cnt_q;
`else
    // No busy-cycle counter in this build.
`endif

endmodule

// File: tb/tb_matmul_feed_ctrl.sv
// Self-checking bench for matmul_feed_ctrl: table of scenarios plus random dimensions,
// checked cycle by cycle against a schedule model and by recomputing the array product from the edge streams.
module tb_matmul_feed_ctrl;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MD = 4;

    logic           clk_i = 1'b0;
    logic           rst_i, start_i;
    logic [2:0]     dim_n_i, dim_k_i, dim_m_i;
    logic [3:0]     a_rd_en_o, b_rd_en_o;
    logic [127:0]   a_rd_addr_o, b_rd_addr_o, a_rd_data_i, b_rd_data_i, left_o, up_o;
    logic           clear_o, busy_o, done_o, err_o;
`ifdef MATMUL_CTRL_CYCLE_CNT_EN
    logic [15:0]    cycle_cnt_o;
`endif

    logic [DW-1:0]  mem_a [16];
    logic [DW-1:0]  mem_b [16];
    logic [DW-1:0]  cap_l [48][4];
    logic [DW-1:0]  cap_u [48][4];
    int nvec, nerr;

    typedef struct {
        int n, k, m;
        int restart_c;
        int rst_c;
        int ident;
        int exp_done;
    } vec_t;
    vec_t tbl [12];

    matmul_feed_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .dim_n_i(dim_n_i), .dim_k_i(dim_k_i), .dim_m_i(dim_m_i),
        .a_rd_en_o(a_rd_en_o), .a_rd_addr_o(a_rd_addr_o), .a_rd_data_i(a_rd_data_i),
        .b_rd_en_o(b_rd_en_o), .b_rd_addr_o(b_rd_addr_o), .b_rd_data_i(b_rd_data_i),
        .left_o(left_o), .up_o(up_o), .clear_o(clear_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
`ifdef MATMUL_CTRL_CYCLE_CNT_EN
        , .cycle_cnt_o(cycle_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Operand banks: one-cycle read latency, junk on lanes that are not enabled.
    always @(posedge clk_i) begin
        logic [127:0] ra, rb;
        for (int i = 0; i < MD; i++) begin
            ra[i*DW +: DW] = a_rd_en_o[i] ? mem_a[a_rd_addr_o[i*AW +: 4]] : DW'($urandom);
            rb[i*DW +: DW] = b_rd_en_o[i] ? mem_b[b_rd_addr_o[i*AW +: 4]] : DW'($urandom);
        end
        a_rd_data_i <= ra;
        b_rd_data_i <= rb;
    end

    task automatic cmp(input string name, input int c, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
        end
    endtask

    // Expected outputs c cycles after the start cycle, from the schedule rules.
    task automatic model(input int n, k, m, c, input bit legal,
                         output logic [3:0] aen, ben, output logic [127:0] aad, bad, lft, upv,
                         output logic clr, bsy, dn, er);
        int tf, d, t, tp;
        aen = '0; ben = '0; aad = '0; bad = '0; lft = '0; upv = '0;
        clr = 0; bsy = 0; dn = 0; er = 0;
        if (!legal) begin
            er = (c == 1);
            return;
        end
        tf = k + ((n > m) ? n : m) - 1;
        d  = n + m;
        t  = c - 2;
        tp = c - 3;
        clr = (c == 1);
        bsy = (c >= 1) && (c <= 1 + tf + d);
        dn  = (c == 2 + tf + d);
        for (int i = 0; i < MD; i++) begin
            if (t >= 0 && t < tf && i < n && t - i >= 0 && t - i < k) begin
                aen[i] = 1'b1;
                aad[i*AW +: AW] = AW'(i * MD + t - i);
            end
            if (t >= 0 && t < tf && i < m && t - i >= 0 && t - i < k) begin
                ben[i] = 1'b1;
                bad[i*AW +: AW] = AW'((t - i) * MD + i);
            end
            if (tp >= 0 && tp < tf && i < n && tp - i >= 0 && tp - i < k)
                lft[i*DW +: DW] = mem_a[i * MD + tp - i];
            if (tp >= 0 && tp < tf && i < m && tp - i >= 0 && tp - i < k)
                upv[i*DW +: DW] = mem_b[(tp - i) * MD + i];
        end
    endtask

    task automatic checkOutput(input int c, input int n, k, m, input bit legal);
        logic [3:0] aen, ben;
        logic [127:0] aad, bad, lft, upv;
        logic clr, bsy, dn, er;
        model(n, k, m, c, legal, aen, ben, aad, bad, lft, upv, clr, bsy, dn, er);
        cmp("a_rd_en", c, a_rd_en_o, aen);
        cmp("b_rd_en", c, b_rd_en_o, ben);
        cmp("a_rd_addr", c, a_rd_addr_o, aad);
        cmp("b_rd_addr", c, b_rd_addr_o, bad);
        cmp("left", c, left_o, lft);
        cmp("up", c, up_o, upv);
        cmp("clear", c, clear_o, clr);
        cmp("busy", c, busy_o, bsy);
        cmp("done", c, done_o, dn);
        cmp("err", c, err_o, er);
    endtask

    task automatic checkIdle(input int c);
        cmp("idle_a_en", c, a_rd_en_o, 0);
        cmp("idle_b_en", c, b_rd_en_o, 0);
        cmp("idle_a_addr", c, a_rd_addr_o, 0);
        cmp("idle_b_addr", c, b_rd_addr_o, 0);
        cmp("idle_left", c, left_o, 0);
        cmp("idle_up", c, up_o, 0);
        cmp("idle_clear", c, clear_o, 0);
        cmp("idle_busy", c, busy_o, 0);
        cmp("idle_done", c, done_o, 0);
        cmp("idle_err", c, err_o, 0);
    endtask

    // Replays the captured edge streams through an ideal systolic array and compares with A*B.
    task automatic checkProduct(input int n, k, m);
        logic [DW-1:0] acc, exp;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < m; j++) begin
                acc = '0;
                exp = '0;
                for (int c = 0; c < 48; c++)
                    if (c - j >= 0 && c - i >= 0) acc += cap_l[c-j][i] * cap_u[c-i][j];
                for (int kk = 0; kk < k; kk++) exp += mem_a[i*MD + kk] * mem_b[kk*MD + j];
                cmp($sformatf("product_%0d_%0d", i, j), 0, acc, exp);
            end
        end
    endtask

    task automatic applyStimulus(input int n, k, m, input int restart_c, input int rst_c, output int done_seen);
        bit legal;
        int last;
        legal = (n >= 1 && n <= MD && k >= 1 && k <= MD && m >= 1 && m <= MD);
        last  = legal ? (3 + k + ((n > m) ? n : m) - 1 + n + m) : 3;
        done_seen = -1;
        for (int c = 0; c < 48; c++)
            for (int i = 0; i < MD; i++) begin
                cap_l[c][i] = '0;
                cap_u[c][i] = '0;
            end
        @(negedge clk_i);
        dim_n_i = 3'(n);
        dim_k_i = 3'(k);
        dim_m_i = 3'(m);
        start_i = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            rst_i   = 1'b0;
            if (rst_c >= 0 && c == rst_c + 1) begin
                checkIdle(c);
                break;
            end
            checkOutput(c, n, k, m, legal);
            if (done_o === 1'b1) done_seen = c;
            for (int i = 0; i < MD; i++) begin
                cap_l[c][i] = left_o[i*DW +: DW];
                cap_u[c][i] = up_o[i*DW +: DW];
            end
            if (c == restart_c) begin
                start_i = 1'b1;
                dim_n_i = 3'd1;
                dim_k_i = 3'd3;
                dim_m_i = 3'd1;
            end
            if (c == rst_c) rst_i = 1'b1;
            if (c >= last) break;
        end
        if (legal && rst_c < 0) checkProduct(n, k, m);
    endtask

    task automatic loadMem(input bit ident);
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = ident ? ((i / MD == i % MD) ? 32'd1 : 32'd0) : $urandom;
            mem_b[i] = ident ? 32'(i + 1) : $urandom;
        end
    endtask

    initial begin
        int seen, n, k, m, tf, expd;
        nvec = 0;
        nerr = 0;
        rst_i = 1'b1;
        start_i = 1'b0;
        dim_n_i = '0;
        dim_k_i = '0;
        dim_m_i = '0;
        loadMem(1'b0);

        tbl[0]  = '{2, 2, 2, -1, -1, 0, 9};
        tbl[1]  = '{4, 4, 4, -1, -1, 1, 17};
        tbl[2]  = '{1, 1, 1, -1, -1, 0, 5};
        tbl[3]  = '{2, 0, 2, -1, -1, 0, -1};
        tbl[4]  = '{5, 2, 2, -1, -1, 0, -1};
        tbl[5]  = '{2, 2, 2, 3, -1, 0, 9};
        tbl[6]  = '{4, 4, 4, -1, 5, 0, -1};
        tbl[7]  = '{2, 2, 2, -1, -1, 0, 9};
        tbl[8]  = '{1, 4, 2, -1, -1, 0, 10};
        tbl[9]  = '{3, 1, 4, -1, -1, 0, 13};
        tbl[10] = '{4, 2, 1, -1, -1, 0, 12};
        tbl[11] = '{2, 2, 0, -1, -1, 0, -1};

        repeat (3) @(negedge clk_i);
        checkIdle(0);
        rst_i = 1'b0;
        @(negedge clk_i);
        checkIdle(0);

        for (int v = 0; v < 12; v++) begin
            loadMem(tbl[v].ident != 0);
            applyStimulus(tbl[v].n, tbl[v].k, tbl[v].m, tbl[v].restart_c, tbl[v].rst_c, seen);
            cmp($sformatf("done_cycle_vec%0d", v), 0, seen, tbl[v].exp_done);
        end

        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(0, 5);
            k = $urandom_range(0, 5);
            m = $urandom_range(0, 5);
            if (n >= 1 && n <= MD && k >= 1 && k <= MD && m >= 1 && m <= MD) begin
                tf   = k + ((n > m) ? n : m) - 1;
                expd = 1 + tf + n + m + 1;
            end else begin
                expd = -1;
            end
            loadMem(1'b0);
            applyStimulus(n, k, m, -1, -1, seen);
            cmp($sformatf("done_cycle_rand%0d", r), 0, seen, expd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
